// File: rtl/scc_mem_dump.sv
// Post-halt data-memory dump engine: on a halt_f rising edge, reads a window of
// data memory one word at a time and streams {addr, data, last} over valid/ready.
module scc_mem_dump #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int BASE_ADDR  = 0,
  parameter int WORD_COUNT = 16384
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              halt_f,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LP_BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   LP_COUNT = (ADDR_W+1)'(WORD_COUNT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_OUT,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_halt_q;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W:0]     r_remaining;
  logic [ADDR_W-1:0]   r_dump_addr;
  logic [DATA_W-1:0]   r_dump_data;
  logic                r_dump_last;
  logic                w_start;

  assign w_start = halt_f & ~r_halt_q;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_start) w_state_nxt = S_ISSUE;
      S_ISSUE:   w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = S_OUT;
      S_OUT:     if (dump_ready) w_state_nxt = r_dump_last ? S_DONE : S_ISSUE;
      S_DONE:    if (!halt_f) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Every register, including the halt edge detector, freezes while clk_en is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_halt_q    <= 1'b0;
      r_addr      <= '0;
      r_remaining <= '0;
      r_dump_addr <= '0;
      r_dump_data <= '0;
      r_dump_last <= 1'b0;
    end else if (clk_en) begin
      r_state  <= w_state_nxt;
      r_halt_q <= halt_f;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_addr      <= LP_BASE;
            r_remaining <= LP_COUNT;
          end
        end
        S_CAPTURE: begin
          r_dump_data <= mem_rd_data;
          r_dump_addr <= r_addr;
          r_dump_last <= (r_remaining == (ADDR_W+1)'(1));
        end
        S_OUT: begin
          if (dump_ready && !r_dump_last) begin
            r_addr      <= r_addr + ADDR_W'(1);
            r_remaining <= r_remaining - (ADDR_W+1)'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Read address is forced to zero outside ISSUE so idle/reset outputs are clean.
  assign mem_rd_en   = (r_state == S_ISSUE);
  assign mem_rd_addr = (r_state == S_ISSUE) ? r_addr : '0;
  assign dump_valid  = (r_state == S_OUT);
  assign dump_addr   = r_dump_addr;
  assign dump_data   = r_dump_data;
  assign dump_last   = r_dump_last;
  assign busy        = (r_state == S_ISSUE) || (r_state == S_CAPTURE) || (r_state == S_OUT);
  assign done        = (r_state == S_DONE);

endmodule

// File: tb/tb_scc_mem_dump.sv
// Bench for scc_mem_dump: directed timing/backpressure/clk_en/reset cases plus
// randomized ready/clk_en runs, checked against an expected word list.
module tb_scc_mem_dump;
  localparam int AW     = 14;
  localparam int DW     = 32;
  localparam int NW     = 4;
  localparam int BASE_A = 100;
  localparam int BASE_B = 16382;

  logic          clk = 1'b0;
  logic          rst;
  logic          clk_en;
  logic          halt_f;
  logic          dump_ready;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] rdata_a;
  logic          dump_valid;
  logic [AW-1:0] dump_addr;
  logic [DW-1:0] dump_data;
  logic          dump_last;
  logic          busy;
  logic          done;

  logic          b_halt;
  logic          b_ready;
  logic          b_rd_en;
  logic [AW-1:0] b_rd_addr;
  logic [DW-1:0] rdata_b;
  logic          b_valid;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;
  logic          b_last;
  logic          b_busy;
  logic          b_done;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW+DW:0] got_a[$];
  logic [AW+DW:0] got_b[$];
  int rd_a;
  int rd_b;
  int n_chk;
  int n_fail;

  always #5 clk = ~clk;

  scc_mem_dump #(.ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(BASE_A), .WORD_COUNT(NW)) u_dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .halt_f(halt_f),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(rdata_a),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
    .dump_data(dump_data), .dump_last(dump_last), .busy(busy), .done(done)
  );

  scc_mem_dump #(.ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(BASE_B), .WORD_COUNT(NW)) u_wrap (
    .clk(clk), .rst(rst), .clk_en(clk_en), .halt_f(b_halt),
    .mem_rd_en(b_rd_en), .mem_rd_addr(b_rd_addr), .mem_rd_data(rdata_b),
    .dump_valid(b_valid), .dump_ready(b_ready), .dump_addr(b_addr),
    .dump_data(b_data), .dump_last(b_last), .busy(b_busy), .done(b_done)
  );

  // Synchronous-read memory: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_rd_en) rdata_a <= mem[mem_rd_addr];
    if (b_rd_en)   rdata_b <= mem[b_rd_addr];
  end

  // Record accepted words and read strobes at enabled edges.
  always @(posedge clk) begin
    if (rst && clk_en) begin
      if (mem_rd_en) rd_a <= rd_a + 1;
      if (b_rd_en)   rd_b <= rd_b + 1;
      if (dump_valid && dump_ready) got_a.push_back({dump_addr, dump_data, dump_last});
      if (b_valid && b_ready)       got_b.push_back({b_addr, b_data, b_last});
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] ctrl_v();
    return 64'({mem_rd_en, mem_rd_addr, dump_valid, dump_last, busy, done});
  endfunction

  function automatic logic [63:0] data_v();
    return 64'({dump_addr, dump_data});
  endfunction

  // Reference: the dump is the words base, base+1, ... (mod 2^AW), last flagged on the final one.
  task automatic check_stream(input int sel, input int base, input int start);
    logic [AW+DW:0] w;
    int n;
    int a;
    n = (sel == 0) ? got_a.size() : got_b.size();
    chk("word_count", 64'(n - start), NW);
    for (int i = 0; i < NW; i++) begin
      if (start + i < n) begin
        w = (sel == 0) ? got_a[start+i] : got_b[start+i];
        a = (base + i) % (1 << AW);
        chk("word_addr", 64'(w[AW+DW:DW+1]), 64'(a));
        chk("word_data", 64'(w[DW:1]), 64'(mem[a]));
        chk("word_last", 64'(w[0]), 64'(i == NW - 1));
      end
    end
  endtask

  task automatic wait_done(input int sel, input int max_cyc);
    int k;
    k = 0;
    while (((sel == 0) ? !done : !b_done) && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    chk("done_reached", 64'((sel == 0) ? done : b_done), 1);
  endtask

  task automatic go_idle();
    @(negedge clk);
    halt_f = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_a, s_b, r0, r1, first_v, done_k, k;
    bit bp, c1, c2;
    logic [AW+DW:0] snap;
    logic [63:0] sc, sd;

    n_chk = 0; n_fail = 0;
    rst = 1'b0; clk_en = 1'b1; halt_f = 1'b1; dump_ready = 1'b1;
    b_halt = 1'b0; b_ready = 1'b1;
    foreach (mem[i]) mem[i] = $urandom;
    mem[100] = 32'h32; mem[101] = 32'h11; mem[102] = 32'h22; mem[103] = 32'h33;

    // Reset held with halt_f high: all outputs zero.
    repeat (3) @(negedge clk);
    chk("rst_ctrl", ctrl_v(), 0);
    chk("rst_data", data_v(), 0);
    chk("rst_wrap", 64'({b_rd_en, b_valid, b_busy, b_done}), 0);

    // Release: halt_f already high starts a dump at the first edge.
    s_a = got_a.size(); r0 = rd_a;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rel_rd_en", 64'(mem_rd_en), 1);
    chk("rel_rd_addr", 64'(mem_rd_addr), BASE_A);
    first_v = -1; done_k = -1;
    for (int e = 1; e <= 14; e++) begin
      @(posedge clk); #1;
      if (dump_valid && first_v < 0) first_v = e;
      if (done && done_k < 0) done_k = e;
    end
    chk("first_valid_edge", 64'(first_v), 2);
    chk("done_edge", 64'(done_k), 3 * NW);
    chk("rd_pulses", 64'(rd_a - r0), NW);
    check_stream(0, BASE_A, s_a);

    // Steady-high halt_f must not start another dump.
    repeat (10) @(posedge clk);
    #1;
    chk("no_retrig_done", 64'(done), 1);
    chk("no_retrig_busy", 64'(busy), 0);
    chk("no_retrig_rd", 64'(rd_a - r0), NW);
    @(negedge clk); halt_f = 1'b0;
    @(posedge clk); #1;
    chk("done_clear", 64'(done), 0);
    @(negedge clk);

    // Backpressure on word 101.
    @(negedge clk); halt_f = 1'b1;
    s_a = got_a.size(); r0 = rd_a; bp = 0; k = 0;
    while (!done && k < 200) begin
      @(negedge clk); k++;
      if (dump_valid && dump_addr == 14'(101) && !bp) begin
        bp = 1;
        snap = {dump_addr, dump_data, dump_last};
        dump_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("bp_hold", 64'({dump_valid, dump_addr, dump_data, dump_last}), 64'({1'b1, snap}));
          chk("bp_no_rd", 64'(mem_rd_en), 0);
        end
        dump_ready = 1'b1;
      end
    end
    chk("bp_seen", 64'(bp), 1);
    chk("bp_done", 64'(done), 1);
    chk("bp_rd", 64'(rd_a - r0), NW);
    check_stream(0, BASE_A, s_a);
    go_idle();

    // clk_en low for 4 cycles in CAPTURE (word 101) and in OUT (word 102, ready high).
    halt_f = 1'b1;
    s_a = got_a.size(); r0 = rd_a; c1 = 0; c2 = 0; k = 0;
    while (!done && k < 200) begin
      @(negedge clk); k++;
      if (!c1 && mem_rd_en && mem_rd_addr == 14'(101)) begin
        @(negedge clk);
        c1 = 1; clk_en = 1'b0; sc = ctrl_v(); sd = data_v();
        repeat (4) begin
          @(negedge clk);
          chk("cen_cap_ctrl", ctrl_v(), sc);
          chk("cen_cap_data", data_v(), sd);
        end
        clk_en = 1'b1;
      end else if (!c2 && dump_valid && dump_addr == 14'(102)) begin
        c2 = 1; clk_en = 1'b0; sc = ctrl_v(); sd = data_v(); r1 = got_a.size();
        repeat (4) begin
          @(negedge clk);
          chk("cen_out_ctrl", ctrl_v(), sc);
          chk("cen_out_data", data_v(), sd);
        end
        chk("cen_out_no_hs", 64'(got_a.size() - r1), 0);
        clk_en = 1'b1;
      end
    end
    chk("cen_seen", 64'({c1, c2}), 2'b11);
    chk("cen_rd", 64'(rd_a - r0), NW);
    check_stream(0, BASE_A, s_a);
    go_idle();

    // halt_f dropped mid-dump: dump completes, done lasts one cycle.
    halt_f = 1'b1;
    s_a = got_a.size(); r0 = rd_a;
    repeat (5) @(negedge clk);
    halt_f = 1'b0;
    wait_done(0, 100);
    @(negedge clk);
    chk("drop_done_pulse", 64'(done), 0);
    chk("drop_idle_busy", 64'(busy), 0);
    chk("drop_rd", 64'(rd_a - r0), NW);
    check_stream(0, BASE_A, s_a);
    @(negedge clk);

    // Randomized ready/clk_en runs over fresh memory contents.
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < NW; i++) mem[BASE_A + i] = $urandom;
      s_a = got_a.size(); r0 = rd_a; k = 0;
      halt_f = 1'b1;
      while (!done && k < 400) begin
        @(negedge clk); k++;
        if (!done) begin
          dump_ready = ($urandom_range(0, 3) != 0);
          clk_en     = ($urandom_range(0, 4) != 0);
        end
      end
      clk_en = 1'b1; dump_ready = 1'b1;
      chk("rand_done", 64'(done), 1);
      chk("rand_rd", 64'(rd_a - r0), NW);
      check_stream(0, BASE_A, s_a);
      go_idle();
    end

    // Address wrap on the second instance.
    b_halt = 1'b1;
    s_b = got_b.size();
    wait_done(1, 100);
    chk("wrap_rd", 64'(rd_b), NW);
    check_stream(1, BASE_B, s_b);
    @(negedge clk); b_halt = 1'b0;

    // Asynchronous reset during OUT.
    halt_f = 1'b1; k = 0;
    while (!dump_valid && k < 50) begin
      @(negedge clk); k++;
    end
    chk("arst_reached_out", 64'(dump_valid), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", 64'(dump_valid), 0);
    chk("arst_ctrl", ctrl_v(), 0);
    chk("arst_data", data_v(), 0);
    repeat (3) begin
      @(negedge clk);
      chk("arst_no_rd", 64'(mem_rd_en), 0);
    end
    halt_f = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("arst_idle", 64'({busy, done, mem_rd_en}), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
